// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator types and constants: pixel width, conv1 feature-map
// dimensions, the signed pixel type and a signed max helper.
package lenet_pkg;

  localparam int DATA_W = 16;
  localparam int C1_W   = 28;
  localparam int C1_H   = 28;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic pixel_t smax(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lenet_pool_linebuf.sv
// Half-width line buffer for the 2x2 max-pool: holds the horizontal maxima of
// the even row so the following odd row can finish each pooling window.
module lenet_pool_linebuf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 14,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  // Not reset: each entry is written on an even row before the odd row reads it.
  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lenet_maxpool2x2.sv
// Streaming 2x2 / stride-2 signed max-pool for the conv1 -> conv2 path.
// Define LENET_POOL_RELU_EN to fuse a ReLU clamp after the max.
module lenet_maxpool2x2 #(
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int IN_W   = lenet_pkg::C1_W,
  parameter int IN_H   = lenet_pkg::C1_H
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);

  import lenet_pkg::*;

  localparam int HALF_W = IN_W / 2;
  localparam int CW     = $clog2(IN_W);
  localparam int RW     = $clog2(IN_H);
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [DATA_W-1:0] pair_reg;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] h_max;
  logic signed [DATA_W-1:0] v_max;
  logic signed [DATA_W-1:0] pooled;
  logic [AW-1:0]            lb_addr;
  logic                     in_fire;
  logic                     out_fire;
  logic                     col_last;
  logic                     row_last;
  logic                     lb_wr;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));
  assign lb_addr  = AW'(col >> 1);
  assign lb_wr    = in_fire && col[0] && !row[0];

  lenet_pool_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (HALF_W),
    .AW     (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (h_max),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  // Horizontal max of the pair, then vertical max against the stored even row.
  always_comb begin
    h_max  = (pair_reg > in_data) ? pair_reg : in_data;
    v_max  = (h_max > lb_rd) ? h_max : lb_rd;
    pooled = v_max;
`ifdef LENET_POOL_RELU_EN
    if (v_max < 0)
      pooled = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      pair_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (in_fire) begin
        // A new result overrides the clear above when both happen together.
        if (!col[0]) begin
          pair_reg <= in_data;
        end else if (row[0]) begin
          out_data  <= pooled;
          out_valid <= 1'b1;
          out_last  <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/lenet_maxpool2x2.md
# lenet_maxpool2x2

Streaming 2×2 / stride-2 max-pool stage for the LeNet accelerator. It sits directly downstream of the conv1 engine: it consumes the conv1 feature map as a raster-scan pixel stream and produces the half-resolution pooled map for conv2. Pooling uses a horizontal pair register and a half-width line buffer, so no full frame is ever buffered.

## Interface
- DATA_W, 16, pixel width (signed two's complement)
- IN_W, 28, input row length in pixels; must be even and ≥2
- IN_H, 28, input row count; must be even and ≥2

- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream pixel valid
- in_ready  output  1  stage can accept a pixel this cycle
- in_data  input  DATA_W  signed conv1 pixel, raster order (row-major, col 0 first)
- out_valid  output  1  pooled pixel valid
- out_ready  input  1  downstream accepts pooled pixel
- out_data  output  DATA_W  signed pooled pixel
- out_last  output  1  high with the final pooled pixel of a frame

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational); no other stall source.
- Counters col (0..IN_W-1) and row (0..IN_H-1) advance only on input transfers; col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame. Next frame starts immediately, with no gap required.
- Even col: pixel captured into pair_reg.
- Odd col, even row: line_buf[col>>1] <= smax(pair_reg, in_data).
- Odd col, odd row: out_data <= smax(smax(pair_reg, in_data), line_buf[col>>1]); out_valid <= 1; out_last <= (row==IN_H-1 && col==IN_W-1).
- smax is a signed comparison at full DATA_W; ties return either operand (same value). No widening or truncation.
- out_valid clears on an output transfer without a concurrent new result. A simultaneous output transfer and new result keeps out_valid high and loads the new data.
- Output order is raster over the (IN_W/2)×(IN_H/2) pooled map; exactly IN_W*IN_H/4 outputs per frame.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0; col, row, pair_reg = 0. line_buf is not reset, because every entry is written on an even row before it is read.
- Latency: the pooled pixel is visible on out_data/out_valid one cycle after the input transfer of the odd-row, odd-col pixel.
- Throughput: 1 input/cycle while out_ready=1. With out_ready=0 and out_valid=1, in_ready drops, so no further input is accepted and no data is lost or overwritten.
- An rst_n assertion mid-frame discards the partial frame. After release, the next accepted pixel is row 0, col 0.
- in_data is ignored when in_valid=0. Counters and state do not move.

## Configuration
- LENET_POOL_RELU_EN defined: the pooled result is clamped to 0 when negative, as a ReLU fused after the max and before the output register. out_data is never negative.
- Undefined: out_data is the raw signed max, and negative values pass through.

## Structure
- lenet_pkg holds DATA_W default, LeNet feature-map dimension constants (C1_W/C1_H = 28), typedef pixel_t (logic signed [DATA_W-1:0]), and the smax function.
- One sub-module: lenet_pool_linebuf, an IN_W/2-deep × DATA_W single-write, single-read register array addressed by col>>1, with read and write in the same cycle to different rows' phases.

## Test plan
- IN_W=IN_H=4, rows [1,5,-3,2],[4,0,7,-8],[9,9,1,1],[-1,10,2,3], out_ready=1. Outputs must be 5, 7, 10, 3, each 1 cycle after its last contributing pixel. out_last must be high only with 3.
- All-negative frame (every pixel -7) with LENET_POOL_RELU_EN undefined: every output is -7. With it defined, every output is 0.
- Backpressure: out_ready=0 while in_valid=1 continuously. After the first pooled output, in_ready=0 and out_data holds 5. Releasing out_ready resumes the stream with no lost or duplicated outputs.
- Back-to-back two frames with no idle cycle: the second frame's outputs match its own reference. out_last must pulse once per frame.
- Reset mid-frame after 6 pixels, then a full fresh frame: outputs match the fresh-frame reference only, and out_valid is 0 during reset.
- Default 28×28 random signed frame versus a scoreboard: exactly 196 outputs, matching bit-exact.
